// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared across the RISC-V pipeline stages and the decode-stage
// controller: the canonical NOP encoding, the major opcode constants and the
// fetch-stage state type.
// No ports (package).
// ----------------------------------------------------------------------------
package pipeline_pkg;

    // addi x0, x0, 0 -- a bubble that decodes as a harmless I-type.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes (instr[6:0]) consumed by the controller.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // BOOT: first read after reset is in flight, nothing to capture yet.
    // RUN : imem_rdata belongs to pc_q and may be loaded into IF/ID.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage : pipeline_pkg

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load enable and synchronous flush. A flush
// (which must be accompanied by load_en_i) writes a bubble: valid 0, pc 0,
// instruction NOP.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (loads the bubble)
//   load_en_i  in   capture next value this edge
//   flush_i    in   capture a bubble instead of the inputs
//   valid_i    in   incoming valid flag
//   pc_i       in   incoming PC
//   instr_i    in   incoming instruction
//   valid_o    out  registered valid flag
//   pc_o       out  registered PC
//   instr_o    out  registered instruction
// ----------------------------------------------------------------------------
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] instr_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] instr_o
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] instr_q, instr_d;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load_en_i) begin
            if (flush_i) begin
                valid_d = 1'b0;
                pc_d    = '0;
                instr_d = INST_W'(NOP_INSTR);
            end else begin
                valid_d = valid_i;
                pc_d    = pc_i;
                instr_d = instr_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= INST_W'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction
// memory (address in cycle t, data in t+1) and loads the IF/ID register.
// Handles load-use stalls (re-read the same address, freeze IF/ID) and EX
// redirects (fetch the target, flush IF/ID with one bubble).
// Priority: reset > redirect > stall > normal.
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   stall         in   hold PC and IF/ID (load-use hazard)
//   redirect      in   taken branch/jump from EX; overrides stall
//   redirect_pc   in   redirect target, bits [1:0] ignored
//   imem_addr     out  instruction-memory read address (combinational)
//   imem_rdata    in   data for the address presented last cycle
//   if_id_valid   out  IF/ID holds a real instruction
//   if_id_pc      out  PC of the IF/ID instruction
//   if_id_instr   out  IF/ID instruction
//   if_id_opcode  out  if_id_instr[6:0] for the controller
// ----------------------------------------------------------------------------
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int               PC_W     = 9,
    parameter int               INST_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [INST_W-1:0] if_id_instr,
    output logic [6:0]        if_id_opcode
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            inflight_v_q, inflight_v_d;

    logic [PC_W-1:0] redirect_addr;
    logic [PC_W-1:0] pc_plus4;
    logic            if_id_load;

    assign redirect_addr = {redirect_pc[PC_W-1:2], 2'b00};
    // Wraps modulo 2^PC_W by construction of the width.
    assign pc_plus4      = pc_q + PC_W'(4);

    // Next-address mux and next-state logic. The address issued this cycle
    // always becomes pc_q, so pc_q names the read whose data arrives next.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inflight_v_d = inflight_v_q;
        imem_addr    = pc_q;
        if_id_load   = 1'b0;

        if (reset) begin
            imem_addr = RESET_PC;
        end else if (redirect) begin
            imem_addr    = redirect_addr;
            pc_d         = redirect_addr;
            inflight_v_d = 1'b1;
            state_d      = RUN;
            if_id_load   = 1'b1;
        end else begin
            unique case (state_q)
                BOOT: begin
                    // First read is in flight; nothing to capture yet.
                    imem_addr    = pc_q;
                    inflight_v_d = 1'b1;
                    state_d      = RUN;
                end
                RUN: begin
                    if (stall) begin
                        // No skid buffer: re-issue pc_q so its data returns
                        // again once the stall lifts.
                        imem_addr = pc_q;
                    end else begin
                        imem_addr  = pc_plus4;
                        pc_d       = pc_plus4;
                        if_id_load = 1'b1;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            inflight_v_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_v_q <= inflight_v_d;
        end
    end

    if_id_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load_en_i (if_id_load),
        .flush_i   (redirect),
        .valid_i   (inflight_v_q),
        .pc_i      (pc_q),
        .instr_i   (imem_rdata),
        .valid_o   (if_id_valid),
        .pc_o      (if_id_pc),
        .instr_o   (if_id_instr)
    );

    assign if_id_opcode = if_id_instr[6:0];

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Memory word[i] = 32'h1000_0000 + i, read
// synchronously. Inputs are driven and outputs checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          PC_W   = 9;
    localparam int          INST_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              if_id_valid;
    logic [PC_W-1:0]   if_id_pc;
    logic [INST_W-1:0] if_id_instr;
    logic [6:0]        if_id_opcode;

    int total = 0;
    int bad   = 0;

    fetch_stage #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .RESET_PC ('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_rdata <= 32'h1000_0000 + 32'(imem_addr[PC_W-1:2]);

    function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
        return 32'h1000_0000 + 32'(a[PC_W-1:2]);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        next_cycle();
        next_cycle();
        #1;
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_pc !== 9'h000) begin bad++; $display("FAIL rst_pc got=%h exp=000", if_id_pc); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, NOP); end
        total++; if (if_id_opcode !== 7'b0010011) begin bad++; $display("FAIL rst_opcode got=%b exp=0010011", if_id_opcode); end
        // Cycle 0 after release: BOOT issues RESET_PC.
        reset = 1'b0;
        #1;
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL boot_addr got=%h exp=000", imem_addr); end
    endtask

    task automatic test_sequential();
        next_cycle(); #1;
        total++; if (imem_addr !== 9'h004) begin bad++; $display("FAIL c1_addr got=%h exp=004", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL c1_valid got=%b exp=0", if_id_valid); end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, if_id_valid); end
            total++; if (if_id_pc !== PC_W'(4*k)) begin bad++; $display("FAIL seq_pc k=%0d got=%h exp=%h", k, if_id_pc, PC_W'(4*k)); end
            total++; if (if_id_instr !== word_at(PC_W'(4*k))) begin bad++; $display("FAIL seq_instr k=%0d got=%h exp=%h", k, if_id_instr, word_at(PC_W'(4*k))); end
            total++; if (imem_addr !== PC_W'(4*k+8)) begin bad++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, imem_addr, PC_W'(4*k+8)); end
        end
    endtask

    // Entered in the cycle IF/ID holds pc 8 (pc_q 12).
    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            if (k != 0) next_cycle();
            stall = 1'b1;
            #1;
            total++; if (if_id_pc !== 9'h008) begin bad++; $display("FAIL stall_pc k=%0d got=%h exp=008", k, if_id_pc); end
            total++; if (imem_addr !== 9'h00C) begin bad++; $display("FAIL stall_addr k=%0d got=%h exp=00c", k, imem_addr); end
        end
        next_cycle();
        stall = 1'b0;
        #1;
        total++; if (if_id_pc !== 9'h008) begin bad++; $display("FAIL stall_rel_pc got=%h exp=008", if_id_pc); end
        total++; if (imem_addr !== 9'h010) begin bad++; $display("FAIL stall_rel_addr got=%h exp=010", imem_addr); end
        next_cycle(); #1;
        total++; if (if_id_pc !== 9'h00C || if_id_instr !== word_at(9'h00C) || if_id_valid !== 1'b1)
            begin bad++; $display("FAIL stall_after1 got pc=%h instr=%h v=%b exp pc=00c instr=%h v=1", if_id_pc, if_id_instr, if_id_valid, word_at(9'h00C)); end
        total++; if (imem_addr !== 9'h014) begin bad++; $display("FAIL stall_after1_addr got=%h exp=014", imem_addr); end
        next_cycle(); #1;
        total++; if (if_id_pc !== 9'h010 || if_id_instr !== word_at(9'h010))
            begin bad++; $display("FAIL stall_after2 got pc=%h instr=%h exp pc=010 instr=%h", if_id_pc, if_id_instr, word_at(9'h010)); end
    endtask

    // Generic redirect: one bubble, then the target and its successor.
    task automatic do_redirect(input logic [PC_W-1:0] target, input logic with_stall,
                               input logic [PC_W-1:0] exp_fetch);
        logic [PC_W-1:0] nxt;
        nxt = exp_fetch + PC_W'(4);
        redirect = 1'b1; redirect_pc = target; stall = with_stall;
        #1;
        total++; if (imem_addr !== exp_fetch) begin bad++; $display("FAIL redir_addr tgt=%h got=%h exp=%h", target, imem_addr, exp_fetch); end
        next_cycle();
        redirect = 1'b0; stall = 1'b0;
        #1;
        total++; if (if_id_valid !== 1'b0 || if_id_pc !== 9'h000 || if_id_instr !== NOP || if_id_opcode !== 7'b0010011)
            begin bad++; $display("FAIL redir_bubble got v=%b pc=%h instr=%h op=%b exp v=0 pc=000 instr=%h op=0010011", if_id_valid, if_id_pc, if_id_instr, if_id_opcode, NOP); end
        total++; if (imem_addr !== nxt) begin bad++; $display("FAIL redir_next_addr got=%h exp=%h", imem_addr, nxt); end
        next_cycle(); #1;
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== exp_fetch || if_id_instr !== word_at(exp_fetch))
            begin bad++; $display("FAIL redir_target got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h", if_id_valid, if_id_pc, if_id_instr, exp_fetch, word_at(exp_fetch)); end
        next_cycle(); #1;
        total++; if (if_id_pc !== nxt || if_id_instr !== word_at(nxt))
            begin bad++; $display("FAIL redir_follow got pc=%h instr=%h exp pc=%h instr=%h", if_id_pc, if_id_instr, nxt, word_at(nxt)); end
    endtask

    task automatic test_redirect();
        do_redirect(9'h040, 1'b0, 9'h040);
    endtask

    task automatic test_stall_redirect();
        do_redirect(9'h020, 1'b1, 9'h020);
    endtask

    task automatic test_wrap();
        // 0x1FF -> fetch 0x1FC, successor wraps to 0x000.
        do_redirect(9'h1FF, 1'b0, 9'h1FC);
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; redirect_pc = 9'h028;
        next_cycle(); redirect = 1'b0;   // bubble
        next_cycle();                    // IF/ID 0x28
        next_cycle();                    // IF/ID 0x2C, pc_q 0x30
        #1;
        total++; if (imem_addr !== 9'h034) begin bad++; $display("FAIL mid_pre_addr got=%h exp=034", imem_addr); end
        reset = 1'b1;
        #1;
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL mid_rst_addr got=%h exp=000", imem_addr); end
        next_cycle();
        #1;
        total++; if (if_id_valid !== 1'b0 || if_id_pc !== 9'h000 || if_id_instr !== NOP)
            begin bad++; $display("FAIL mid_rst_vals got v=%b pc=%h instr=%h exp v=0 pc=000 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP); end
        reset = 1'b0;
        #1;
        total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL mid_boot_addr got=%h exp=000", imem_addr); end
        next_cycle(); #1;
        total++; if (imem_addr !== 9'h004 || if_id_valid !== 1'b0)
            begin bad++; $display("FAIL mid_c1 got addr=%h v=%b exp addr=004 v=0", imem_addr, if_id_valid); end
        next_cycle(); #1;
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 9'h000 || if_id_instr !== word_at(9'h000))
            begin bad++; $display("FAIL mid_c2 got v=%b pc=%h instr=%h exp v=1 pc=000 instr=%h", if_id_valid, if_id_pc, if_id_instr, word_at(9'h000)); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_stage
